// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave controller: pad modes and the
// standard edge-count targets for the command, address and data phases.
package spi_slave_pkg;

    typedef enum logic [1:0] {
        SPI_STD_TX  = 2'd0,
        SPI_STD_RX  = 2'd1,
        SPI_QUAD_TX = 2'd2,
        SPI_QUAD_RX = 2'd3
    } spi_mode_e;

    // Edge-count targets; edges per word = target + 1
    localparam logic [7:0] CMD_BITS_STD  = 8'd7;   // 8 edges x 1 bit
    localparam logic [7:0] CMD_BITS_QUAD = 8'd1;   // 2 edges x 4 bits
    localparam logic [7:0] ADDR_BITS_TGT = 8'h1F;  // 32-bit address, std
    localparam logic [7:0] DATA_BITS_TGT = 8'h07;  // 32-bit data, quad

endpackage : spi_slave_pkg

// File: rtl/spi_slave_bitcnt.sv
// Edge counter with a loadable target. Flags a match when the count has
// reached (or, after a late target reload, passed) the target, so a
// shrinking target finishes the word on the next edge instead of wrapping.
// Shared between the RX deserializer and the TX serializer.
module spi_slave_bitcnt
    import spi_slave_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic [CNT_W-1:0] flush_target_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             match_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] target_q;
    logic [CNT_W-1:0] target_d;
    logic             match_s;

    assign match_s = (cnt_q >= target_q);
    assign match_o = match_s;

    // Next count and next target for a normal (non-flush) edge
    always_comb begin
        cnt_d    = cnt_q;
        target_d = target_q;
        if (match_s) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (load_i) begin
            target_d = load_val_i;
        end else begin
            target_d = target_q;
        end
    end

    // Counter/target registers; reset and flush both restore the command target
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            cnt_q    <= {CNT_W{1'b0}};
            target_q <= flush_target_i;
        end else begin
            cnt_q    <= cnt_d;
            target_q <= target_d;
        end
    end

endmodule : spi_slave_bitcnt

// File: rtl/spi_slave_rx_deser.sv
// SPI slave receive deserializer: samples sdi in std (1-bit) or quad
// (4-bit) mode, MSB first, and presents each completed word with a
// one-cycle valid pulse. Optional completed-word counter is enabled by
// defining SPI_RX_WORD_CNT_EN; otherwise words_rx_o is tied to zero.
module spi_slave_rx_deser
    import spi_slave_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int CNT_W         = 8,
    parameter int CMD_BITS_STD  = int'(spi_slave_pkg::CMD_BITS_STD),
    parameter int CMD_BITS_QUAD = int'(spi_slave_pkg::CMD_BITS_QUAD)
) (
    input  logic              sclk_i,
    input  logic              rst_i,
    input  logic              cs_i,
    input  logic              en_quad_i,
    input  logic [3:0]        sdi_i,
    input  logic [CNT_W-1:0]  counter_in_i,
    input  logic              counter_in_upd_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o,
    output logic [15:0]       words_rx_o
);

    spi_mode_e         mode_s;
    logic [CNT_W-1:0]  cmd_target_s;
    logic              match_s;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [DATA_W-1:0] data_q;
    logic              data_valid_q;

    assign mode_s       = en_quad_i ? SPI_QUAD_RX : SPI_STD_RX;
    assign cmd_target_s = en_quad_i ? CNT_W'(CMD_BITS_QUAD) : CNT_W'(CMD_BITS_STD);

    spi_slave_bitcnt #(
        .CNT_W (CNT_W)
    ) u_bitcnt (
        .clk_i          (sclk_i),
        .rst_i          (rst_i),
        .flush_i        (cs_i),
        .flush_target_i (cmd_target_s),
        .load_i         (counter_in_upd_i),
        .load_val_i     (counter_in_i),
        .match_o        (match_s)
    );

    // Shift register value including this edge's pad bits
    always_comb begin
        shift_d = shift_q;
        case (mode_s)
            SPI_QUAD_RX: shift_d = {shift_q[DATA_W-5:0], sdi_i};
            SPI_STD_RX:  shift_d = {shift_q[DATA_W-2:0], sdi_i[0]};
            default:     shift_d = {shift_q[DATA_W-2:0], sdi_i[0]};
        endcase
    end

    // Shift register, output word and valid pulse; cs flushes all but data
    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            shift_q      <= {DATA_W{1'b0}};
            data_q       <= {DATA_W{1'b0}};
            data_valid_q <= 1'b0;
        end else if (cs_i) begin
            shift_q      <= {DATA_W{1'b0}};
            data_valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            if (match_s) begin
                data_q       <= shift_d;
                data_valid_q <= 1'b1;
            end else begin
                data_valid_q <= 1'b0;
            end
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = data_valid_q;

`ifdef SPI_RX_WORD_CNT_EN
    logic [15:0] words_rx_q;

    // Completed-word count; survives cs, cleared only by reset, wraps at 16 bits
    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            words_rx_q <= 16'd0;
        end else if (!cs_i && match_s) begin
            words_rx_q <= words_rx_q + 16'd1;
        end else begin
            words_rx_q <= words_rx_q;
        end
    end

    assign words_rx_o = words_rx_q;
`else
    assign words_rx_o = 16'd0;
`endif

endmodule : spi_slave_rx_deser
